// File: rtl/cmd_resp_checker.sv
// cmd_resp_checker: runs one command/response transaction against a
// RemoteComm-style peer. It sends the command, waits for the response within a
// cycle budget, compares it with the expected code, optionally checks that
// resp_rdy falls again, and keeps saturating pass/fail tallies.
module cmd_resp_checker #(
  parameter int unsigned CMD_W      = 16,
  parameter int unsigned RESP_W     = 8,
  parameter int unsigned TO_W       = 20,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned CHECK_FALL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic [RESP_W-1:0] exp_resp,
  input  logic [TO_W-1:0]   timeout_cyc,
  input  logic              clr_cnt,
  output logic [CMD_W-1:0]  cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        err_code,
  output logic [RESP_W-1:0] resp_cap,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SNT,
    WAIT_RESP,
    CHK_FALL,
    FINISH
  } state_t;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_TO_SNT   = 3'd1;
  localparam logic [2:0] ERR_TO_RESP  = 3'd2;
  localparam logic [2:0] ERR_MISMATCH = 3'd3;
  localparam logic [2:0] ERR_STUCK    = 3'd4;
  localparam logic [2:0] ERR_EARLY    = 3'd5;

  localparam bit FALL_EN = (CHECK_FALL != 0);

  state_t            state;
  state_t            state_nx;
  logic [2:0]        err_r;
  logic [2:0]        err_nx;
  logic              cap_now;
  logic [RESP_W-1:0] exp_r;
  logic [TO_W-1:0]   limit;
  logic [TO_W-1:0]   timer;
  logic              timed_out;
  logic              resp_bad;

  // The timer saturates and the budget test uses >=, so a command accepted on
  // the limit cycle still leaves a bounded wait for the response instead of
  // letting the timer run past the limit and wrap.
  assign timed_out = (timer >= limit);
  assign resp_bad  = (resp != exp_r);

  // Next-state and error decision for the transaction sequencer.
  always_comb begin
    state_nx = state;
    err_nx   = err_r;
    cap_now  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SEND;
          err_nx   = ERR_OK;
        end
      end
      SEND: begin
        state_nx = WAIT_SNT;
      end
      WAIT_SNT: begin
        if (resp_rdy && !cmd_snt) begin
          err_nx   = ERR_EARLY;
          state_nx = FINISH;
        end else if (cmd_snt && resp_rdy) begin
          cap_now  = 1'b1;
          err_nx   = resp_bad ? ERR_MISMATCH : ERR_OK;
          state_nx = FALL_EN ? CHK_FALL : FINISH;
        end else if (cmd_snt) begin
          state_nx = WAIT_RESP;
        end else if (timed_out) begin
          err_nx   = ERR_TO_SNT;
          state_nx = FINISH;
        end
      end
      WAIT_RESP: begin
        if (resp_rdy) begin
          cap_now  = 1'b1;
          err_nx   = resp_bad ? ERR_MISMATCH : ERR_OK;
          state_nx = FALL_EN ? CHK_FALL : FINISH;
        end else if (timed_out) begin
          err_nx   = ERR_TO_RESP;
          state_nx = FINISH;
        end
      end
      CHK_FALL: begin
        if (resp_rdy && (err_r == ERR_OK)) begin
          err_nx = ERR_STUCK;
        end
        state_nx = FINISH;
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, latched transaction parameters, registered outputs and tallies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      err_r    <= ERR_OK;
      exp_r    <= '0;
      limit    <= '0;
      timer    <= '0;
      cmd      <= '0;
      snd_cmd  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_code <= ERR_OK;
      resp_cap <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      state   <= state_nx;
      err_r   <= err_nx;
      busy    <= (state_nx != IDLE);
      snd_cmd <= (state_nx == SEND);
      done    <= (state_nx == FINISH);

      if ((state == IDLE) && start) begin
        cmd   <= cmd_in;
        exp_r <= exp_resp;
        limit <= (timeout_cyc == '0) ? '1 : timeout_cyc;
        timer <= '0;
      end else if (((state == WAIT_SNT) || (state == WAIT_RESP)) && (timer != '1)) begin
        timer <= timer + 1'b1;
      end

      if (cap_now) begin
        resp_cap <= resp;
      end

      if (state_nx == FINISH) begin
        err_code <= err_nx;
        pass     <= (err_nx == ERR_OK);
      end

      // The tally moves while FINISH is showing, so a clear in that cycle wins.
      if (clr_cnt) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
      end else if (state == FINISH) begin
        if (pass) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_resp_checker.sv
// tb_cmd_resp_checker: directed transactions against two checker instances
// (falling-edge check enabled and disabled). Expected outcomes are queued at
// issue time and retired by a monitor whenever done is seen.
module tb_cmd_resp_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        cmd_snt = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [15:0] cmd_in = '0;
  logic [7:0]  exp_resp = '0;
  logic [7:0]  resp = '0;
  logic [19:0] timeout_cyc = '0;

  logic [15:0] cmd;
  logic        snd_cmd, busy, done, pass;
  logic [2:0]  err_code;
  logic [7:0]  resp_cap, pass_cnt, fail_cnt;

  logic [15:0] nf_cmd;
  logic        nf_snd_cmd, nf_busy, nf_done, nf_pass;
  logic [2:0]  nf_err_code;
  logic [7:0]  nf_resp_cap, nf_pass_cnt, nf_fail_cnt;

  typedef struct {
    logic       p;
    logic [2:0] e;
    logic [7:0] cap;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  int         snd_seen = 0;
  int         snd_expected = 0;
  logic       nf_pass_last = 1'b0;
  logic [2:0] nf_err_last = 3'd7;
  int         lat;

  cmd_resp_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_in(cmd_in), .exp_resp(exp_resp),
    .timeout_cyc(timeout_cyc), .clr_cnt(clr_cnt), .cmd(cmd), .snd_cmd(snd_cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
    .pass(pass), .err_code(err_code), .resp_cap(resp_cap), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt)
  );

  cmd_resp_checker #(.CHECK_FALL(0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_in(cmd_in), .exp_resp(exp_resp),
    .timeout_cyc(timeout_cyc), .clr_cnt(clr_cnt), .cmd(nf_cmd), .snd_cmd(nf_snd_cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(nf_busy), .done(nf_done),
    .pass(nf_pass), .err_code(nf_err_code), .resp_cap(nf_resp_cap), .pass_cnt(nf_pass_cnt),
    .fail_cnt(nf_fail_cnt)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input logic [15:0] c, input logic [7:0] e, input logic [19:0] t);
    cmd_in      = c;
    exp_resp    = e;
    timeout_cyc = t;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    snd_expected++;
  endtask

  task automatic applyStimulus(input logic [15:0] c, input logic [7:0] e, input logic [19:0] t,
                               input logic p, input logic [2:0] err, input logic [7:0] cap);
    sb.push_back('{p: p, e: err, cap: cap});
    pulseStart(c, e, t);
  endtask

  // Well-behaved peer: cmd_snt after snt_wait WAIT_SNT cycles, then resp_rdy for rsp_len cycles.
  task automatic peer(input int snt_wait, input int rsp_len, input logic [7:0] val);
    tick();
    repeat (snt_wait) tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt  = 1'b0;
    resp_rdy = 1'b1;
    resp     = val;
    repeat (rsp_len) tick();
    resp_rdy = 1'b0;
  endtask

  task automatic waitDone(input int maxc, input string name, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < maxc) begin
      tick();
      cyc++;
    end
    if (done !== 1'b1) checkOutput({name, "_done_seen"}, 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: retires one expected outcome per done pulse.
  always @(negedge clk) begin
    if (snd_cmd === 1'b1) snd_seen++;
    if (nf_done === 1'b1) begin
      nf_pass_last = nf_pass;
      nf_err_last  = nf_err_code;
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_pass", pass, mon_e.p);
        checkOutput("sb_err_code", err_code, mon_e.e);
        checkOutput("sb_resp_cap", resp_cap, mon_e.cap);
      end
    end
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed transaction sequence.
  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_snd_cmd", snd_cmd, 0);
    checkOutput("rst_cmd", cmd, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_pass_cnt", pass_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Calibration command 0x0000 expecting 0xA5.
    applyStimulus(16'h0000, 8'hA5, 20'd500000, 1'b1, 3'd0, 8'hA5);
    checkOutput("cal_snd_cmd", snd_cmd, 1);
    checkOutput("cal_busy", busy, 1);
    peer(0, 1, 8'hA5);
    checkOutput("cal_done_early", done, 0);
    waitDone(10, "cal", lat);
    checkOutput("cal_done_lat", lat, 1);
    tick();
    checkOutput("cal_pass_cnt", pass_cnt, 1);
    checkOutput("cal_busy_end", busy, 0);

    // Wrong response, resp_rdy also left high: mismatch outranks stuck-high.
    applyStimulus(16'h1234, 8'hA5, 20'd500000, 1'b0, 3'd3, 8'h5A);
    peer(0, 2, 8'h5A);
    waitDone(10, "mism", lat);
    tick();
    checkOutput("mism_fail_cnt", fail_cnt, 1);

    // cmd_snt never arrives: WAIT_SNT spans timer values 0..100.
    applyStimulus(16'h00C1, 8'h01, 20'd100, 1'b0, 3'd1, 8'h5A);
    waitDone(200, "to_snt", lat);
    checkOutput("to_snt_lat", lat, 102);
    tick();

    // cmd_snt arrives but the response never does.
    applyStimulus(16'h00C2, 8'h01, 20'd20, 1'b0, 3'd2, 8'h5A);
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    waitDone(100, "to_resp", lat);
    tick();

    // cmd_snt on the exact limit cycle beats the timeout.
    applyStimulus(16'h00C3, 8'h3C, 20'd10, 1'b1, 3'd0, 8'h3C);
    peer(10, 1, 8'h3C);
    waitDone(10, "limit", lat);
    tick();

    // resp_rdy high for two cycles with correct data.
    applyStimulus(16'h0010, 8'hA5, 20'd500000, 1'b0, 3'd4, 8'hA5);
    peer(0, 2, 8'hA5);
    waitDone(10, "stuck", lat);
    tick();
    checkOutput("nf_stuck_pass", nf_pass_last, 1);
    checkOutput("nf_stuck_err", nf_err_last, 0);

    // start pulsed while busy must not disturb the latched command/expectation.
    applyStimulus(16'h0BAD, 8'h11, 20'd50, 1'b1, 3'd0, 8'h11);
    tick();
    cmd_in = 16'hFFFF;
    exp_resp = 8'h22;
    timeout_cyc = 20'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_cmd_held", cmd, 16'h0BAD);
    checkOutput("busy_still", busy, 1);
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    resp_rdy = 1'b1;
    resp = 8'h11;
    tick();
    resp_rdy = 1'b0;
    waitDone(10, "busy", lat);
    tick();

    // resp_rdy before cmd_snt.
    applyStimulus(16'h0E00, 8'h77, 20'd50, 1'b0, 3'd5, 8'h11);
    tick();
    resp_rdy = 1'b1;
    resp = 8'h77;
    tick();
    resp_rdy = 1'b0;
    checkOutput("early_done", done, 1);
    waitDone(10, "early", lat);
    tick();

    // cmd_snt and resp_rdy together in WAIT_SNT.
    applyStimulus(16'h0C0C, 8'h42, 20'd50, 1'b1, 3'd0, 8'h42);
    tick();
    cmd_snt = 1'b1;
    resp_rdy = 1'b1;
    resp = 8'h42;
    tick();
    cmd_snt = 1'b0;
    resp_rdy = 1'b0;
    waitDone(10, "combo", lat);
    checkOutput("combo_lat", lat, 1);
    tick();
    checkOutput("tally_pass_cnt", pass_cnt, 4);
    checkOutput("tally_fail_cnt", fail_cnt, 5);

    // clr_cnt coinciding with the FINISH increment.
    applyStimulus(16'h0099, 8'h99, 20'd50, 1'b1, 3'd0, 8'h99);
    peer(0, 1, 8'h99);
    waitDone(10, "clr", lat);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checkOutput("clr_pass_cnt", pass_cnt, 0);
    checkOutput("clr_fail_cnt", fail_cnt, 0);

    // 300 passes with timeout_cyc=0 (maximum budget): pass_cnt saturates.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] v;
      v = 8'(i);
      applyStimulus(16'(i), v, 20'd0, 1'b1, 3'd0, v);
      peer(0, 1, v);
      waitDone(10, "loop", lat);
      tick();
    end
    checkOutput("sat_pass_cnt", pass_cnt, 8'hFF);
    checkOutput("sat_fail_cnt", fail_cnt, 0);
    checkOutput("sat_resp_cap", resp_cap, 8'h2B);

    // Reset while waiting for the response: no done pulse may follow.
    pulseStart(16'h0DEF, 8'h01, 20'd50);
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    checkOutput("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_done", done, 0);
    checkOutput("mid_cmd", cmd, 0);
    checkOutput("mid_pass_cnt", pass_cnt, 0);
    checkOutput("mid_resp_cap", resp_cap, 0);
    checkOutput("mid_nf_busy", nf_busy, 0);
    checkOutput("mid_nf_snd_cmd", nf_snd_cmd, 0);
    checkOutput("mid_nf_cmd", nf_cmd, 0);
    checkOutput("mid_nf_resp_cap", nf_resp_cap, 0);
    checkOutput("mid_nf_pass_cnt", nf_pass_cnt, 0);
    checkOutput("mid_nf_fail_cnt", nf_fail_cnt, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_done", done, 0);

    checkOutput("snd_count", snd_seen, snd_expected);
    checkOutput("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
